alu_pkt_tx: RTL and testbench

- Packet encoder for the host end of the UART ALU command protocol: builds command packets and feeds them byte by byte into a UART transmitter (8-bit AXI-stream style).
- Used as an on-FPGA traffic generator and loopback driver that sends commands to a second ALU instance, and in simulation as the bench-side packet source.
- Each packet is a 4-byte header followed by N 32-bit operands, sent little-endian.

---
 rtl/alu_pkt_pkg.sv | 36 +++
 rtl/alu_pkt_tx_word_to_bytes.sv | 44 ++++
 rtl/alu_pkt_tx.sv | 133 +++++++++++++
 tb/tb_alu_pkt_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkt_pkg.sv
// Shared types and constants for the ALU command packet encoder.
// Packet layout: {LEN[15:8], LEN[7:0], reserved, opcode}, then operands, all LSB first.
package alu_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        OPND_GET,
        OPND_SEND,
        FIN
    } state_t;

    localparam int          HDR_BYTES     = 4;
    localparam logic [7:0]  RESERVED_BYTE = 8'h00;

    localparam logic [7:0]  OP_ECHO = 8'hEC;
    localparam logic [7:0]  OP_ADD  = 8'hAD;
    localparam logic [7:0]  OP_MUL  = 8'h88;
    localparam logic [7:0]  OP_DIV  = 8'h89;

    typedef struct packed {
        logic [15:0] len;
        logic [7:0]  opcode;
    } pkt_hdr_t;

    // Total packet length in bytes for n operands.
    function automatic logic [15:0] pkt_len(input logic [15:0] n);
        return 16'(HDR_BYTES) + (n << 2);
    endfunction

    // Header as a 32-bit word so it can share the operand serializer.
    function automatic logic [31:0] hdr_word(input pkt_hdr_t h);
        return {h.len, RESERVED_BYTE, h.opcode};
    endfunction

endpackage

// File: rtl/alu_pkt_tx_word_to_bytes.sv
// 32-bit load, 8-bit valid/ready serializer, least significant byte first.
// A load is only issued by the parent while the serializer is idle.
import alu_pkt_pkg::*;

module word_to_bytes (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic [7:0]  tdata_o,
    output logic        tvalid_o,
    input  logic        tready_i,
    output logic        last_o,
    output logic        last_xfer_o
);

    logic [31:0] sh;
    logic [1:0]  idx;
    logic        vld;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh  <= '0;
            idx <= '0;
            vld <= 1'b0;
        end else if (load_i) begin
            sh  <= word_i;
            idx <= '0;
            vld <= 1'b1;
        end else if (vld && tready_i) begin
            // Shift toward the LSB so tdata always comes straight from a flop.
            sh  <= {8'h00, sh[31:8]};
            idx <= idx + 2'd1;
            if (idx == 2'd3)
                vld <= 1'b0;
        end
    end

    assign tdata_o     = sh[7:0];
    assign tvalid_o    = vld;
    assign last_o      = vld && (idx == 2'd3);
    assign last_xfer_o = last_o && tready_i;

endmodule

// File: rtl/alu_pkt_tx.sv
// Host-side ALU command packet encoder: header then N little-endian operand
// words, streamed a byte at a time into a UART transmitter.
import alu_pkt_pkg::*;

module alu_pkt_tx #(
    parameter int MAX_OPERANDS = 16,
    parameter int CNT_W        = $clog2(MAX_OPERANDS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [7:0]       cmd_opcode_i,
    input  logic [CNT_W-1:0] cmd_count_i,
    input  logic             opnd_valid_i,
    output logic             opnd_ready_o,
    input  logic [31:0]      opnd_data_i,
    output logic [7:0]       m_axis_tdata_o,
    output logic             m_axis_tvalid_o,
    input  logic             m_axis_tready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    state_t           state;
    logic [CNT_W-1:0] remaining;

    logic        oversize;
    logic        cmd_hs;
    logic        opnd_hs;
    logic        ser_load;
    logic [31:0] ser_word;
    logic        ser_last;
    logic        ser_last_xfer;
    pkt_hdr_t    hdr;

    assign oversize = cmd_count_i > CNT_W'(MAX_OPERANDS);
    assign cmd_hs   = (state == IDLE) && cmd_valid_i && cmd_ready_o;
    assign opnd_hs  = (state == OPND_GET) && opnd_valid_i && opnd_ready_o;

    // The header is loaded on the accept edge itself so its first byte is
    // valid one cycle after the command handshake.
    always_comb begin
        hdr        = '0;
        hdr.opcode = cmd_opcode_i;
        hdr.len    = pkt_len(16'(cmd_count_i));
        ser_load   = (cmd_hs && !oversize) || opnd_hs;
        ser_word   = opnd_hs ? opnd_data_i : hdr_word(hdr);
    end

    word_to_bytes u_ser (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (ser_load),
        .word_i      (ser_word),
        .tdata_o     (m_axis_tdata_o),
        .tvalid_o    (m_axis_tvalid_o),
        .tready_i    (m_axis_tready_i),
        .last_o      (ser_last),
        .last_xfer_o (ser_last_xfer)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            remaining    <= '0;
            cmd_ready_o  <= 1'b0;
            opnd_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_hs) begin
                        if (oversize) begin
                            err_o <= 1'b1;
                        end else begin
                            remaining   <= cmd_count_i;
                            busy_o      <= 1'b1;
                            cmd_ready_o <= 1'b0;
                            state       <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (ser_last_xfer) begin
                        if (remaining != '0) begin
                            opnd_ready_o <= 1'b1;
                            state        <= OPND_GET;
                        end else begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= FIN;
                        end
                    end
                end
                OPND_GET: begin
                    if (opnd_hs) begin
                        opnd_ready_o <= 1'b0;
                        state        <= OPND_SEND;
                    end
                end
                OPND_SEND: begin
                    if (ser_last_xfer) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= FIN;
                        end else begin
                            opnd_ready_o <= 1'b1;
                            state        <= OPND_GET;
                        end
                    end
                end
                FIN: begin
                    cmd_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ser_last;

endmodule

// File: tb/tb_alu_pkt_tx.sv
// Self-checking bench for alu_pkt_tx: directed table, reset/backpressure
// sequences and random packets against a byte-list packet model.
import alu_pkt_pkg::*;

module tb_alu_pkt_tx;

    localparam int MAXO  = 16;
    localparam int CNT_W = $clog2(MAXO + 1);

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [7:0]       cmd_opcode_i = '0;
    logic [CNT_W-1:0] cmd_count_i = '0;
    logic             opnd_valid_i = 1'b0;
    logic             opnd_ready_o;
    logic [31:0]      opnd_data_i = '0;
    logic [7:0]       m_axis_tdata_o;
    logic             m_axis_tvalid_o;
    logic             m_axis_tready_i = 1'b1;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    alu_pkt_tx #(.MAX_OPERANDS(MAXO)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_opcode_i    (cmd_opcode_i),
        .cmd_count_i     (cmd_count_i),
        .opnd_valid_i    (opnd_valid_i),
        .opnd_ready_o    (opnd_ready_o),
        .opnd_data_i     (opnd_data_i),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] op;
        int         n;
        int         bp;        // percent of cycles with tready low
        int         gap;       // percent of cycles with opnd_valid low
        int         opmode;    // 0 random, 1 add pair, 2 operand k = k
        bit         hold_next; // present next command while this one is busy
        bit         exp_err;
        int         exp_len;
        int         exp_nbytes;
    } vec_t;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0]  cap_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] ops_q[$];
    logic [31:0] opnd_q[$];

    int   bp_pct = 0, gap_pct = 0, cyc = 0;
    int   opnd_rdy_cycles = 0, opnd_hs_cnt = 0;
    bit   last_cmd_hs, byte_hs, byte_hs_prev, opnd_hs;
    bit   saw_tvalid, ready_busy, done_wide, err_wide, hold_pending;
    logic [7:0] hold_data;
    logic tvalid_s, busy_s, done_s, err_s, cmd_ready_s, opnd_ready_s;
    logic [7:0] tdata_s;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference packet: header then operands, every multi-byte field LSB first.
    function automatic void build_exp(input logic [7:0] op, input int n);
        int len;
        exp_q.delete();
        len = 4 + 4 * n;
        exp_q.push_back(op);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(len % 256));
        exp_q.push_back(8'(len / 256));
        foreach (ops_q[i])
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((ops_q[i] >> (8 * b)) & 32'hFF));
    endfunction

    // One clock: sample everything at negedge, then drive after the posedge.
    task automatic cycle();
        @(negedge clk_i);
        cyc++;
        tvalid_s     = m_axis_tvalid_o;
        tdata_s      = m_axis_tdata_o;
        busy_s       = busy_o;
        cmd_ready_s  = cmd_ready_o;
        opnd_ready_s = opnd_ready_o;
        if (done_o === 1'b1 && done_s === 1'b1) done_wide = 1;
        if (err_o === 1'b1 && err_s === 1'b1) err_wide = 1;
        done_s       = done_o;
        err_s        = err_o;
        last_cmd_hs  = (cmd_valid_i && cmd_ready_o === 1'b1);
        byte_hs_prev = byte_hs;
        byte_hs      = (m_axis_tvalid_o === 1'b1) && m_axis_tready_i;
        opnd_hs      = opnd_valid_i && (opnd_ready_o === 1'b1);
        if (byte_hs) cap_q.push_back(m_axis_tdata_o);
        if (m_axis_tvalid_o === 1'b1) saw_tvalid = 1;
        if (opnd_ready_o === 1'b1) opnd_rdy_cycles++;
        if (opnd_hs) opnd_hs_cnt++;
        if (busy_o === 1'b1 && cmd_ready_o === 1'b1) ready_busy = 1;
        if (hold_pending)
            chk(m_axis_tvalid_o === 1'b1 && m_axis_tdata_o === hold_data, "hold_stable",
                {m_axis_tvalid_o, m_axis_tdata_o}, {1'b1, hold_data});
        hold_pending = (m_axis_tvalid_o === 1'b1) && !m_axis_tready_i && !rst_i;
        hold_data    = m_axis_tdata_o;
        @(posedge clk_i);
        #1;
        if (opnd_hs && opnd_q.size() != 0) void'(opnd_q.pop_front());
        m_axis_tready_i = ($urandom_range(99) >= bp_pct);
        opnd_valid_i    = (opnd_q.size() != 0) && ($urandom_range(99) >= gap_pct);
        opnd_data_i     = (opnd_q.size() != 0) ? opnd_q[0] : 32'h0;
    endtask

    task automatic run_packet(input vec_t v, input vec_t nxt, input int abort_at);
        logic [31:0] w;
        bit acc;
        int a, mis;
        bp_pct = v.bp;
        gap_pct = v.gap;
        ops_q.delete();
        if (!v.exp_err)
            for (int k = 0; k < v.n; k++) begin
                if (v.opmode == 1)      w = (k == 0) ? 32'h11223344 : 32'hDEADBEEF;
                else if (v.opmode == 2) w = 32'(k);
                else                    w = $urandom;
                ops_q.push_back(w);
                opnd_q.push_back(w);
            end
        build_exp(v.op, v.exp_err ? 0 : v.n);
        cmd_opcode_i = v.op;
        cmd_count_i  = CNT_W'(v.n);
        cmd_valid_i  = 1'b1;
        ready_busy   = 0;
        acc = 0;
        for (int k = 0; k < 300 && !acc; k++) begin
            cycle();
            acc = last_cmd_hs;
        end
        chk(acc, "cmd_accept", 32'(acc), 1);
        if (v.hold_next) begin
            cmd_opcode_i = nxt.op;
            cmd_count_i  = CNT_W'(nxt.n);
        end else begin
            cmd_valid_i = 1'b0;
        end
        if (!acc) begin
            cmd_valid_i = 1'b0;
            opnd_q.delete();
            return;
        end
        if (v.exp_err) begin
            saw_tvalid = 0;
            cycle();
            chk(err_s === 1'b1, "err_pulse", 32'(err_s), 1);
            chk(busy_s === 1'b0, "err_busy_low", 32'(busy_s), 0);
            repeat (3) cycle();
            chk(!saw_tvalid && err_s === 1'b0, "err_no_bytes", {saw_tvalid, err_s}, 0);
            return;
        end
        cap_q.delete();
        a = cyc;
        opnd_rdy_cycles = 0;
        opnd_hs_cnt = 0;
        cycle();
        chk(tvalid_s === 1'b1, "first_byte_latency", 32'(tvalid_s), 1);
        if (abort_at > 0) begin
            while (cap_q.size() < abort_at && cyc - a < 3000) cycle();
            return;
        end
        while (done_s !== 1'b1 && cyc - a < 3000) cycle();
        chk(done_s === 1'b1, "done_seen", 32'(done_s), 1);
        chk(byte_hs_prev && cap_q.size() == exp_q.size(), "done_on_last_byte",
            32'(cap_q.size()), 32'(exp_q.size()));
        chk(busy_s === 1'b0, "busy_clear", 32'(busy_s), 0);
        chk(cap_q.size() == v.exp_nbytes, "nbytes", 32'(cap_q.size()), 32'(v.exp_nbytes));
        if (cap_q.size() >= 4)
            chk({cap_q[3], cap_q[2]} == 16'(v.exp_len), "len_field", {cap_q[3], cap_q[2]}, 32'(v.exp_len));
        mis = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (mis < 0 && cap_q[i] !== exp_q[i]) mis = i;
        chk(mis < 0 && cap_q.size() == exp_q.size(), "bytes",
            (mis < 0) ? 32'(cap_q.size()) : 32'(cap_q[mis]),
            (mis < 0) ? 32'(exp_q.size()) : 32'(exp_q[mis]));
        chk(!ready_busy, "no_cmd_ready_while_busy", 32'(ready_busy), 0);
        chk(opnd_hs_cnt == v.n, "opnd_fetches", 32'(opnd_hs_cnt), 32'(v.n));
        if (v.gap == 0)
            chk(opnd_rdy_cycles == v.n, "opnd_ready_cycles", 32'(opnd_rdy_cycles), 32'(v.n));
        if (v.bp == 0 && v.gap == 0)
            chk(cyc - a == v.exp_nbytes + v.n + 1, "packet_cycles",
                32'(cyc - a), 32'(v.exp_nbytes + v.n + 1));
    endtask

    vec_t tbl[7];
    vec_t rv, zero_v;

    initial begin
        tbl[0] = '{OP_ECHO,  0,  0, 0, 0, 0, 0, 16'h0004,  4};
        tbl[1] = '{OP_ADD,   2,  0, 0, 1, 0, 0, 16'h000C, 12};
        tbl[2] = '{OP_ADD,   2, 30, 0, 1, 0, 0, 16'h000C, 12};
        tbl[3] = '{OP_MUL,  17,  0, 0, 0, 0, 1, 0,         0};
        tbl[4] = '{OP_DIV,   1,  0, 0, 0, 0, 0, 16'h0008,  8};
        tbl[5] = '{OP_MUL,  16,  0, 0, 2, 1, 0, 16'h0044, 68};
        tbl[6] = '{OP_ECHO,  0, 20, 0, 0, 0, 0, 16'h0004,  4};
        zero_v = tbl[0];

        // Reset state
        repeat (3) cycle();
        chk({cmd_ready_s, opnd_ready_s, tvalid_s, busy_s, done_s, err_s} === 6'b0 && tdata_s === 8'h00,
            "reset_outputs", {cmd_ready_s, opnd_ready_s, tvalid_s, busy_s, done_s, err_s, tdata_s}, 0);
        rst_i = 1'b0;
        cycle();
        chk(cmd_ready_s === 1'b0, "ready_before_release", 32'(cmd_ready_s), 0);
        cycle();
        chk(cmd_ready_s === 1'b1, "ready_after_release", 32'(cmd_ready_s), 1);

        for (int i = 0; i < 7; i++)
            run_packet(tbl[i], (i < 6) ? tbl[i + 1] : tbl[i], 0);

        // Reset after the 6th byte of the add packet
        run_packet(tbl[1], tbl[1], 6);
        chk(cap_q.size() == 6, "abort_point", 32'(cap_q.size()), 6);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        opnd_q.delete();
        hold_pending = 0;
        cycle();
        chk({cmd_ready_s, opnd_ready_s, tvalid_s, busy_s, done_s, err_s} === 6'b0 && tdata_s === 8'h00,
            "midpkt_reset_outputs", {cmd_ready_s, opnd_ready_s, tvalid_s, busy_s, done_s, err_s, tdata_s}, 0);
        saw_tvalid = 0;
        repeat (4) cycle();
        chk(!saw_tvalid && cmd_ready_s === 1'b1, "abandoned_packet_silent", {saw_tvalid, cmd_ready_s}, 1);
        run_packet(zero_v, zero_v, 0);
        saw_tvalid = 0;
        repeat (6) cycle();
        chk(!saw_tvalid, "exactly_four_bytes", 32'(saw_tvalid), 0);

        // Random packets
        for (int i = 0; i < 24; i++) begin
            rv.op = (i % 4 == 0) ? OP_ECHO : (i % 4 == 1) ? OP_ADD : (i % 4 == 2) ? OP_MUL : OP_DIV;
            rv.n  = ($urandom_range(9) == 0) ? MAXO + 1 + int'($urandom_range(MAXO - 2))
                                             : int'($urandom_range(6));
            rv.bp        = int'($urandom_range(50));
            rv.gap       = (i % 3 == 0) ? 0 : int'($urandom_range(40));
            rv.opmode    = 0;
            rv.hold_next = 0;
            rv.exp_err   = rv.n > MAXO;
            rv.exp_len   = rv.exp_err ? 0 : 4 + 4 * rv.n;
            rv.exp_nbytes = rv.exp_err ? 0 : 4 + 4 * rv.n;
            run_packet(rv, rv, 0);
            repeat (int'($urandom_range(3))) cycle();
        end

        chk(!done_wide, "done_single_cycle", 32'(done_wide), 0);
        chk(!err_wide, "err_single_cycle", 32'(err_wide), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
